// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings used by the controller, datapath and immediate extender.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRWB   = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags expiry on the last allowed cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_ready,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (i_active && !i_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  // A ready on the final cycle completes the access rather than expiring it.
  assign o_expire = (TIMEOUT > 0) && i_active && !i_ready && (cnt_q == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback with memory timeout and illegal-opcode trap.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 16,
  parameter bit          ILLEGAL_TRAP = 1'b1,
  parameter int unsigned CNT_W        = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_memReady,
  output logic       o_memReq,
  output logic       o_memWrite,
  output logic       o_adrSrc,
  output logic       o_irWrite,
  output logic       o_pcUpdate,
  output logic       o_branch,
  output logic       o_regWrite,
  output logic [1:0] o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [2:0] o_immSrc,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_ALUOp,
  output logic       o_illegal,
  output logic       o_memTimeout,
  output logic [3:0] o_state
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   timeout_q, timeout_d;
  logic   bad_op;
  logic   expire;

  mem_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_active (is_mem_state(state_q)),
    .i_ready  (i_memReady),
    .o_expire (expire)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    bad_op    = 1'b0;
    unique case (state_q)
      S_FETCH:    if (i_memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           if (i_funct3 == 3'b000) state_d = S_JALR;
                             else                    bad_op  = 1'b1;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           bad_op  = 1'b1;
        endcase
        if (bad_op) begin
          if (ILLEGAL_TRAP) begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_MEMADR:   state_d = (i_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (i_memReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (i_memReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRWB;
      S_JALRWB:   state_d = S_FETCH;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
    endcase
    if (expire) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Decodes are masked by reset so a request is withdrawn the moment reset asserts.
  always_comb begin
    o_memReq    = 1'b0;
    o_memWrite  = 1'b0;
    o_adrSrc    = 1'b0;
    o_irWrite   = 1'b0;
    o_pcUpdate  = 1'b0;
    o_branch    = 1'b0;
    o_regWrite  = 1'b0;
    o_ALUSrcA   = SRCA_PC;
    o_ALUSrcB   = SRCB_RS2;
    o_immSrc    = IMM_I;
    o_resultSrc = RES_ALUOUT;
    o_ALUOp     = ALUOP_ADD;
    if (i_rst_n) begin
      case (state_q)
        S_FETCH: begin
          o_memReq    = 1'b1;
          o_ALUSrcB   = SRCB_FOUR;
          o_resultSrc = RES_ALURESULT;
          o_irWrite   = i_memReady;
          o_pcUpdate  = i_memReady;
        end
        S_DECODE: begin
          o_ALUSrcA = SRCA_OLDPC;
          o_ALUSrcB = SRCB_IMM;
          o_immSrc  = IMM_B;
        end
        S_MEMADR: begin
          o_ALUSrcA = SRCA_RS1;
          o_ALUSrcB = SRCB_IMM;
          o_immSrc  = (i_opcode == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          o_memReq = 1'b1;
          o_adrSrc = 1'b1;
        end
        S_MEMWB: begin
          o_regWrite  = 1'b1;
          o_resultSrc = RES_READDATA;
        end
        S_MEMWRITE: begin
          o_memReq   = 1'b1;
          o_memWrite = 1'b1;
          o_adrSrc   = 1'b1;
        end
        S_EXECR: begin
          o_ALUSrcA = SRCA_RS1;
          o_ALUOp   = ALUOP_FUNCT;
        end
        S_EXECI: begin
          o_ALUSrcA = SRCA_RS1;
          o_ALUSrcB = SRCB_IMM;
          o_ALUOp   = ALUOP_FUNCT;
        end
        S_ALUWB:  o_regWrite = 1'b1;
        S_BRANCH: begin
          o_ALUSrcA = SRCA_RS1;
          o_ALUOp   = ALUOP_SUB;
          o_branch  = 1'b1;
        end
        S_JAL: begin
          o_ALUSrcA  = SRCA_OLDPC;
          o_ALUSrcB  = SRCB_FOUR;
          o_pcUpdate = 1'b1;
        end
        S_JALR: begin
          o_ALUSrcA   = SRCA_RS1;
          o_ALUSrcB   = SRCB_IMM;
          o_resultSrc = RES_ALURESULT;
          o_pcUpdate  = 1'b1;
        end
        S_JALRWB: begin
          o_ALUSrcA   = SRCA_OLDPC;
          o_ALUSrcB   = SRCB_FOUR;
          o_resultSrc = RES_ALURESULT;
          o_regWrite  = 1'b1;
        end
        S_LUI: begin
          o_ALUSrcB = SRCB_IMM;
          o_immSrc  = IMM_U;
          o_ALUOp   = ALUOP_PASSB;
        end
        S_AUIPC: begin
          o_ALUSrcA = SRCA_OLDPC;
          o_ALUSrcB = SRCB_IMM;
          o_immSrc  = IMM_U;
        end
        default: ;
      endcase
    end
  end

  assign o_illegal    = illegal_q;
  assign o_memTimeout = timeout_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: default, no-trap and short-timeout instances.
module tb_multicycle_controller;
  import riscv_pkg::*;

  logic clk;
  int   vecs = 0;
  int   errs = 0;

  // default instance
  logic       rst_n, rdy;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       m_memReq, m_memWrite, m_adrSrc, m_irWrite, m_pcUpdate, m_branch, m_regWrite;
  logic [1:0] m_srcA, m_srcB, m_res, m_aluOp;
  logic [2:0] m_imm;
  logic       m_ill, m_to;
  logic [3:0] m_state;

  // shared inputs of the no-trap and short-timeout instances
  logic       rst_b, rdy_b;
  logic [6:0] op_b;
  logic [2:0] f3_b;
  logic       n_memReq, n_memWrite, n_adrSrc, n_irWrite, n_pcUpdate, n_branch, n_regWrite;
  logic [1:0] n_srcA, n_srcB, n_res, n_aluOp;
  logic [2:0] n_imm;
  logic       n_ill, n_to;
  logic [3:0] n_state;
  logic       t_memReq, t_memWrite, t_adrSrc, t_irWrite, t_pcUpdate, t_branch, t_regWrite;
  logic [1:0] t_srcA, t_srcB, t_res, t_aluOp;
  logic [2:0] t_imm;
  logic       t_ill, t_to;
  logic [3:0] t_state;

  multicycle_controller dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opc), .i_funct3(f3), .i_memReady(rdy),
    .o_memReq(m_memReq), .o_memWrite(m_memWrite), .o_adrSrc(m_adrSrc), .o_irWrite(m_irWrite),
    .o_pcUpdate(m_pcUpdate), .o_branch(m_branch), .o_regWrite(m_regWrite), .o_ALUSrcA(m_srcA),
    .o_ALUSrcB(m_srcB), .o_immSrc(m_imm), .o_resultSrc(m_res), .o_ALUOp(m_aluOp),
    .o_illegal(m_ill), .o_memTimeout(m_to), .o_state(m_state));

  multicycle_controller #(.ILLEGAL_TRAP(1'b0)) dut_nt (
    .i_clk(clk), .i_rst_n(rst_b), .i_opcode(op_b), .i_funct3(f3_b), .i_memReady(rdy_b),
    .o_memReq(n_memReq), .o_memWrite(n_memWrite), .o_adrSrc(n_adrSrc), .o_irWrite(n_irWrite),
    .o_pcUpdate(n_pcUpdate), .o_branch(n_branch), .o_regWrite(n_regWrite), .o_ALUSrcA(n_srcA),
    .o_ALUSrcB(n_srcB), .o_immSrc(n_imm), .o_resultSrc(n_res), .o_ALUOp(n_aluOp),
    .o_illegal(n_ill), .o_memTimeout(n_to), .o_state(n_state));

  multicycle_controller #(.TIMEOUT(4), .CNT_W(3)) dut_to (
    .i_clk(clk), .i_rst_n(rst_b), .i_opcode(op_b), .i_funct3(f3_b), .i_memReady(rdy_b),
    .o_memReq(t_memReq), .o_memWrite(t_memWrite), .o_adrSrc(t_adrSrc), .o_irWrite(t_irWrite),
    .o_pcUpdate(t_pcUpdate), .o_branch(t_branch), .o_regWrite(t_regWrite), .o_ALUSrcA(t_srcA),
    .o_ALUSrcB(t_srcB), .o_immSrc(t_imm), .o_resultSrc(t_res), .o_ALUOp(t_aluOp),
    .o_illegal(t_ill), .o_memTimeout(t_to), .o_state(t_state));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b0; opc = OP_LOAD; f3 = 3'b000;
    rst_b = 1'b0; rdy_b = 1'b1; op_b = 7'h7F; f3_b = 3'b000;
    #12;
    chk("rst_state", m_state, S_FETCH);
    chk("rst_memReq", m_memReq, 0);
    chk("rst_irWrite", m_irWrite, 0);
    chk("rst_illegal", m_ill, 0);
    chk("rst_timeout", m_to, 0);
    cyc();
    rst_n = 1'b1; #1;

    // LW with one-cycle-late ready in FETCH and MEMREAD
    chk("lw_f1_state", m_state, S_FETCH);
    chk("lw_f1_memReq", m_memReq, 1);
    chk("lw_f1_adrSrc", m_adrSrc, 0);
    chk("lw_f1_irWrite", m_irWrite, 0);
    chk("lw_f1_srcB", m_srcB, 2'b10);
    chk("lw_f1_res", m_res, 2'b10);
    cyc(); rdy = 1'b1; #1;
    chk("lw_f2_state", m_state, S_FETCH);
    chk("lw_f2_irWrite", m_irWrite, 1);
    chk("lw_f2_pcUpdate", m_pcUpdate, 1);
    cyc(); rdy = 1'b0; #1;
    chk("lw_dec_state", m_state, S_DECODE);
    chk("lw_dec_imm", m_imm, 3'b010);
    chk("lw_dec_srcA", m_srcA, 2'b01);
    chk("lw_dec_memReq", m_memReq, 0);
    cyc(); #1;
    chk("lw_adr_state", m_state, S_MEMADR);
    chk("lw_adr_imm", m_imm, 3'b000);
    chk("lw_adr_srcA", m_srcA, 2'b10);
    chk("lw_adr_srcB", m_srcB, 2'b01);
    cyc(); #1;
    chk("lw_rd1_state", m_state, S_MEMREAD);
    chk("lw_rd1_memReq", m_memReq, 1);
    chk("lw_rd1_adrSrc", m_adrSrc, 1);
    chk("lw_rd1_regWrite", m_regWrite, 0);
    cyc(); rdy = 1'b1; #1;
    chk("lw_rd2_state", m_state, S_MEMREAD);
    cyc(); rdy = 1'b0; #1;
    chk("lw_wb_state", m_state, S_MEMWB);
    chk("lw_wb_regWrite", m_regWrite, 1);
    chk("lw_wb_res", m_res, 2'b01);
    chk("lw_wb_memReq", m_memReq, 0);
    cyc(); #1;
    chk("lw_end_state", m_state, S_FETCH);
    chk("lw_end_regWrite", m_regWrite, 0);

    // SW, ready immediately (ready also high in DECODE/MEMADR where it is ignored)
    opc = OP_STORE; rdy = 1'b1; #1;
    chk("sw_f_irWrite", m_irWrite, 1);
    cyc(); #1;
    chk("sw_dec_state", m_state, S_DECODE);
    cyc(); #1;
    chk("sw_adr_state", m_state, S_MEMADR);
    chk("sw_adr_imm", m_imm, 3'b001);
    cyc(); #1;
    chk("sw_wr_state", m_state, S_MEMWRITE);
    chk("sw_wr_memReq", m_memReq, 1);
    chk("sw_wr_memWrite", m_memWrite, 1);
    chk("sw_wr_adrSrc", m_adrSrc, 1);
    cyc(); #1;
    chk("sw_end_state", m_state, S_FETCH);
    chk("sw_end_memWrite", m_memWrite, 0);

    // BEQ
    opc = OP_BRANCH; #1;
    cyc(); #1;
    chk("beq_dec_imm", m_imm, 3'b010);
    cyc(); #1;
    chk("beq_br_state", m_state, S_BRANCH);
    chk("beq_br_branch", m_branch, 1);
    chk("beq_br_aluOp", m_aluOp, 2'b01);
    chk("beq_br_srcA", m_srcA, 2'b10);
    cyc(); #1;
    chk("beq_end_state", m_state, S_FETCH);
    chk("beq_end_branch", m_branch, 0);

    // JAL
    opc = OP_JAL; cyc(); #1;
    chk("jal_dec_state", m_state, S_DECODE);
    cyc(); #1;
    chk("jal_state", m_state, S_JAL);
    chk("jal_pcUpdate", m_pcUpdate, 1);
    chk("jal_srcA", m_srcA, 2'b01);
    chk("jal_srcB", m_srcB, 2'b10);
    cyc(); #1;
    chk("jal_wb_state", m_state, S_ALUWB);
    chk("jal_wb_regWrite", m_regWrite, 1);
    chk("jal_wb_res", m_res, 2'b00);
    cyc(); #1;
    chk("jal_end_state", m_state, S_FETCH);

    // LUI
    opc = OP_LUI; cyc(); cyc(); #1;
    chk("lui_state", m_state, S_LUI);
    chk("lui_imm", m_imm, 3'b100);
    chk("lui_aluOp", m_aluOp, 2'b11);
    chk("lui_srcB", m_srcB, 2'b01);
    cyc(); cyc(); #1;
    chk("lui_end_state", m_state, S_FETCH);

    // reset pulse in the middle of a MEMREAD wait
    opc = OP_LOAD; cyc(); rdy = 1'b0; #1;
    chk("rr_dec_state", m_state, S_DECODE);
    cyc(); cyc(); #1;
    chk("rr_rd_memReq", m_memReq, 1);
    chk("rr_rd_state", m_state, S_MEMREAD);
    rst_n = 1'b0; #1;
    chk("rr_async_memReq", m_memReq, 0);
    chk("rr_async_state", m_state, S_FETCH);
    cyc(); rst_n = 1'b1; #1;
    chk("rr_rel_state", m_state, S_FETCH);
    chk("rr_rel_memReq", m_memReq, 1);
    chk("rr_rel_illegal", m_ill, 0);
    chk("rr_rel_timeout", m_to, 0);

    // illegal opcode traps and stays
    opc = 7'h7F; rdy = 1'b1; #1;
    cyc(); #1;
    chk("ill_dec_state", m_state, S_DECODE);
    cyc(); #1;
    chk("ill_state", m_state, S_TRAP);
    chk("ill_flag", m_ill, 1);
    chk("ill_memReq", m_memReq, 0);
    chk("ill_timeout", m_to, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(); rdy = 1'($urandom_range(0, 1)); #1;
      chk("ill_hold_state", m_state, S_TRAP);
    end
    chk("ill_hold_flag", m_ill, 1);
    chk("ill_hold_regWrite", m_regWrite, 0);

    // JALR with non-zero funct3 is illegal
    rst_n = 1'b0; #2;
    rst_n = 1'b1; opc = OP_JALR; f3 = 3'b001; rdy = 1'b1; #1;
    chk("jalr_bad_rst_flag", m_ill, 0);
    cyc(); cyc(); #1;
    chk("jalr_bad_state", m_state, S_TRAP);
    chk("jalr_bad_flag", m_ill, 1);

    // ILLEGAL_TRAP=0 treats the opcode as a NOP; default instance traps
    rst_b = 1'b1; #1;
    chk("nt_f_state", n_state, S_FETCH);
    cyc(); #1;
    chk("nt_dec_state", n_state, S_DECODE);
    cyc(); #1;
    chk("nt_end_state", n_state, S_FETCH);
    chk("nt_end_flag", n_ill, 0);
    chk("nt_ref_trap", t_state, S_TRAP);

    // TIMEOUT=4: four not-ready FETCH cycles then TRAP
    rst_b = 1'b0; op_b = OP_RTYPE; rdy_b = 1'b0; #1;
    rst_b = 1'b1; #1;
    chk("to_c1_state", t_state, S_FETCH);
    cyc(); cyc(); cyc(); #1;
    chk("to_c4_state", t_state, S_FETCH);
    chk("to_c4_flag", t_to, 0);
    cyc(); #1;
    chk("to_trap_state", t_state, S_TRAP);
    chk("to_trap_flag", t_to, 1);
    chk("to_trap_ill", t_ill, 0);
    chk("to_trap_memReq", t_memReq, 0);

    // ready on the fourth cycle wins
    rst_b = 1'b0; #1;
    chk("to_rst_flag", t_to, 0);
    rst_b = 1'b1; #1;
    cyc(); cyc(); cyc(); rdy_b = 1'b1; #1;
    chk("nto_c4_irWrite", t_irWrite, 1);
    cyc(); #1;
    chk("nto_dec_state", t_state, S_DECODE);
    chk("nto_dec_flag", t_to, 0);
    cyc(); #1;
    chk("nto_ex_state", t_state, S_EXECR);
    chk("nto_ex_aluOp", t_aluOp, 2'b10);
    cyc(); #1;
    chk("nto_wb_regWrite", t_regWrite, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Next-generation control unit for the RV32I core. It replaces the single-cycle combinational main decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over multiple cycles.
- Drives datapath mux selects and enables, and handshakes with a variable-latency unified memory.
- Adds two behaviours the single-cycle unit lacks: a memory-wait timeout and illegal-opcode trapping.

Parameters:
TIMEOUT, 16, max wait cycles for i_memReady per access; 0 disables timeout
ILLEGAL_TRAP, 1, 1 = illegal opcode enters TRAP; 0 = treated as NOP (back to FETCH)
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_opcode  in  7  instr[6:0] from IR (valid from DECODE onward)
i_funct3  in  3  instr[14:12] (passed through, only checked for legality)
i_memReady  in  1  memory completes current access this cycle
o_memReq  out  1  memory access request
o_memWrite  out  1  write qualifier for o_memReq
o_adrSrc  out  1  0 = PC, 1 = ALUOut as memory address
o_irWrite  out  1  latch fetched word into IR and PC into oldPC
o_pcUpdate  out  1  unconditional PC write
o_branch  out  1  PC write if branch condition true
o_regWrite  out  1  register file write enable
o_ALUSrcA  out  2  00 PC, 01 oldPC, 10 rs1
o_ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4
o_immSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
o_resultSrc  out  2  00 ALUOut, 01 readData, 10 ALUResult
o_ALUOp  out  2  00 add, 01 sub (branch compare), 10 decode funct
o_illegal  out  1  sticky, high in TRAP due to illegal opcode
o_memTimeout  out  1  sticky, high in TRAP due to timeout
o_state  out  4  current state encoding (debug)

Behaviour:
- Reset (async, i_rst_n=0): state=FETCH, timeout counter=0, sticky flags=0, all enables 0. The FETCH Moore outputs (o_memReq=1, o_adrSrc=0) appear once reset deasserts.
- Enables not listed for a state are 0.
- All outputs are Moore decodes of the state, except o_irWrite and o_pcUpdate in FETCH, which are gated by i_memReady.
- FETCH:
  - Outputs: memReq=1, adrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, resultSrc=10.
  - When i_memReady=1: irWrite=1, pcUpdate=1 (PC<=PC+4); next state DECODE. Otherwise hold in FETCH.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, immSrc=010, ALUOp=00 (branch target into ALUOut).
  - Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC.
  - Any other opcode: TRAP (sets o_illegal) if ILLEGAL_TRAP=1, else FETCH.
  - JALR with funct3!=000 counts as illegal.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. immSrc=001 if opcode is STORE, else 000. Next: MEMWRITE for STORE, MEMREAD for LOAD.
- MEMREAD: memReq=1, adrSrc=1; on i_memReady -> MEMWB.
- MEMWB: regWrite=1, resultSrc=01 -> FETCH.
- MEMWRITE: memReq=1, memWrite=1, adrSrc=1; on i_memReady -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, immSrc=000, ALUOp=10 -> ALUWB.
- ALUWB: regWrite=1, resultSrc=00 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, resultSrc=00, branch=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, resultSrc=00, pcUpdate=1 -> ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, immSrc=000, ALUOp=00, resultSrc=10, pcUpdate=1 -> JALRWB.
- JALRWB: ALUSrcA=01, ALUSrcB=10, ALUOp=00, resultSrc=10, regWrite=1 -> FETCH.
- LUI: immSrc=100, ALUSrcB=01; ALU passes imm (ALUSrcA ignored, ALUOp=11 reserved = pass B) -> ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, immSrc=100, ALUOp=00 -> ALUWB.
- TRAP: all enables 0; remain until reset.
- Timeout counter:
  - Counts each cycle in FETCH/MEMREAD/MEMWRITE while i_memReady=0; clears on state exit.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 with i_memReady still 0: next state TRAP, o_memTimeout set.
  - i_memReady=1 on that same cycle wins (access completes, no timeout).
- i_memReady outside request states is ignored.
- Reset mid-access drops o_memReq in the same cycle (async).

Decomposition:
- Shared package riscv_pkg: opcode localparams, state enum (4-bit), and the immSrc/ALUSrcA/ALUSrcB/resultSrc/ALUOp encodings (reused by datapath and immediate extender).
- One natural sub-module, mem_wait_timer: counter, TIMEOUT compare, expire output.

Test Plan:
- Reset then LW (0000011), memReady 1 cycle late in FETCH and MEMREAD -> states FETCH,FETCH,DECODE,MEMADR,MEMREAD,MEMREAD,MEMWB,FETCH; regWrite=1 and resultSrc=01 only in MEMWB.
- SW (0100011), memReady immediate -> MEMADR with immSrc=001; MEMWRITE with memReq=1, memWrite=1, adrSrc=1; 4 cycles total.
- BEQ (1100011) -> DECODE immSrc=010; BRANCH with branch=1, ALUOp=01; back to FETCH in 3 cycles.
- Opcode 1111111 with ILLEGAL_TRAP=1 -> TRAP, o_illegal=1, stays for 20 cycles. With ILLEGAL_TRAP=0 -> FETCH after DECODE, o_illegal=0.
- TIMEOUT=4, memReady held 0 in FETCH -> TRAP after 4 FETCH cycles, o_memTimeout=1. memReady=1 on the 4th cycle -> DECODE, no timeout.
- i_rst_n pulsed low mid-MEMREAD -> o_memReq=0 immediately; state FETCH and flags 0 after release.
